err_ctrl_distributor: RTL and testbench
=======================================

Name: err_ctrl_distributor

Overview:
- Parametrised, sequential successor to the single-bit error-control splitter in the errorInjector design.
- Accepts error-injection commands over a valid/ready handshake and routes each one to one of N_SUB sub-injector channels.
- Each channel has its own state machine that drives its SUB_W-bit error mask for one cycle, for a counted burst, or continuously until stopped or aborted.
- Sits between the injector control front end and the per-unit sub-injectors.

Parameters:
- N_SUB, 4: number of sub-injector channels, range 1..16.
- SUB_W, 8: width of each channel's error mask.
- CNT_W, 8: width of the burst-length field and the per-channel counter.
- CH_W (localparam): $clog2(N_SUB)+1. All-ones in cmd_chan is therefore never a valid channel index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_chan  in  CH_W  target channel index.
- cmd_mode  in  2  00 ONESHOT, 01 BURST, 10 CONT, 11 STOP.
- cmd_mask  in  SUB_W  error mask to apply.
- cmd_len  in  CNT_W  burst length in cycles, BURST mode only.
- abort  in  1  synchronous stop of all channels.
- sub_err_ctrl  out  N_SUB*SUB_W  per-channel masks; channel i occupies bits [i*SUB_W +: SUB_W].
- sub_active  out  N_SUB  channel i is currently driving.
- busy  out  1  OR of sub_active.
- bad_chan  out  1  sticky flag: a command targeted an out-of-range channel.

Behaviour:
- Reset (async assert, sync-released by rst_n high at clock): every channel to IDLE; sub_err_ctrl=0, sub_active=0, busy=0, bad_chan=0. The cmd_ready combinational term reflects the reset state.
- Reset mid-burst truncates immediately; no residual mask bits are output.
- All outputs are registered except cmd_ready, which is combinational from state and inputs.
- cmd_ready = !abort && (cmd_mode==STOP || chan out of range || sub_active[cmd_chan]==0).
- Out-of-range cmd_chan (>= N_SUB, non-broadcast): command is accepted and dropped; bad_chan set next cycle; no channel is affected. bad_chan is cleared only by reset.
- Latency: command accepted on edge N. Channel mask appears on sub_err_ctrl and sub_active rises from cycle N+1.
- Per-channel FSM states: IDLE, ACTIVE_ONE, ACTIVE_BURST, ACTIVE_CONT.
  - IDLE + ONESHOT -> ACTIVE_ONE: mask driven exactly 1 cycle, then IDLE.
  - IDLE + BURST -> ACTIVE_BURST: counter loaded with cmd_len; mask driven exactly cmd_len cycles; cmd_len==0 is treated as 1. Counter decrements each cycle; at count 1 the FSM returns to IDLE.
  - IDLE + CONT -> ACTIVE_CONT: mask held until STOP to that channel or abort.
  - STOP to any state -> IDLE; output zero from the next cycle. STOP to an IDLE channel is a no-op and is still accepted.
- A channel in IDLE drives zero mask and sub_active=0.
- abort: all channels to IDLE, outputs zero next cycle; cmd_ready=0 while abort is high, so abort always wins over a simultaneous command.
- Different channels run independently. A command to channel j does not perturb channel k.
- Back-to-back commands to the same channel: the second is stalled (cmd_ready=0) until the first completes. For a burst ending at cycle M, the channel is IDLE at M+1 and the new command is accepted at M+1.
- Mask bits are passed through unmodified; no arithmetic on mask. Counter never wraps: it stops at the IDLE transition.

Optional Feature:
- Macro ERR_SPLIT_BCAST_EN.
- With it defined:
  - cmd_chan all-ones is a broadcast: the command is applied to every channel simultaneously.
  - A broadcast is accepted only when busy==0, or when cmd_mode==STOP (stops all channels).
  - A broadcast does not set bad_chan.
- Without it: all-ones is treated as any other out-of-range index (dropped, bad_chan set). No broadcast logic is synthesised.

Test Plan:
- Reset with cmd_valid=0, then release -> all outputs 0, cmd_ready=1.
- ONESHOT ch1, mask 0xA5 -> sub_err_ctrl[15:8]=0xA5 for exactly one cycle, starting one cycle after acceptance; other lanes 0.
- BURST ch0, len 3, mask 0x0F, plus a second BURST ch0 issued immediately after -> ch0 mask high 3 cycles. cmd_ready low for the second command until ch0 returns to IDLE, then accepted. Repeat with len 0 -> 1 cycle.
- CONT ch2, mask 0xFF; STOP ch2 after 10 cycles; CONT ch3 in parallel then abort asserted together with a cmd_valid -> ch2 held 0xFF for 10 cycles then 0. Abort clears ch3 next cycle; the simultaneous command is not accepted.
- cmd_chan=5 with N_SUB=4 -> command accepted, no lane changes, bad_chan=1 and sticky until rst_n low.
- Under ERR_SPLIT_BCAST_EN, cmd_chan=7, BURST len 2, mask 0x3C while idle -> all four lanes 0x3C for 2 cycles. The same stimulus with the macro undefined -> no lane activity and bad_chan=1.

Source files
------------

// File: rtl/err_ctrl_distributor.sv
// Routes error-injection commands to N_SUB per-channel mask generators.
// Optional broadcast on the all-ones channel index: define ERR_SPLIT_BCAST_EN.

module err_ctrl_lane #(
  parameter int SUB_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             hit,
  input  logic [1:0]       mode,
  input  logic [SUB_W-1:0] mask,
  input  logic [CNT_W-1:0] len,
  output logic [SUB_W-1:0] err,
  output logic             active,
  output logic             act_nxt
);
  localparam logic [1:0] M_ONE = 2'd0, M_BURST = 2'd1, M_CONT = 2'd2, M_STOP = 2'd3;

  typedef enum logic [1:0] {IDLE, ACTIVE_ONE, ACTIVE_BURST, ACTIVE_CONT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] mask_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err     <= '0;
      active  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= mask_d;
      active  <= act_nxt;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = err;
    unique case (state_q)
      IDLE: if (hit) begin
        unique case (mode)
          M_ONE:   begin state_d = ACTIVE_ONE;  mask_d = mask; end
          M_BURST: begin
            state_d = ACTIVE_BURST;
            mask_d  = mask;
            cnt_d   = (len == '0) ? CNT_W'(1) : len;
          end
          M_CONT:  begin state_d = ACTIVE_CONT; mask_d = mask; end
          default: ;
        endcase
      end
      ACTIVE_ONE:   state_d = IDLE;
      ACTIVE_BURST: if (cnt_q <= CNT_W'(1)) state_d = IDLE;
                    else cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
    if (hit && mode == M_STOP) state_d = IDLE;
    if (abort)                 state_d = IDLE;
    // Idle lanes output zero and park the counter so it never wraps.
    if (state_d == IDLE) begin
      mask_d = '0;
      cnt_d  = '0;
    end
    act_nxt = (state_d != IDLE);
  end
endmodule

module err_ctrl_distributor #(
  parameter int N_SUB = 4,
  parameter int SUB_W = 8,
  parameter int CNT_W = 8,
  localparam int CH_W = $clog2(N_SUB) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CH_W-1:0]        cmd_chan,
  input  logic [1:0]             cmd_mode,
  input  logic [SUB_W-1:0]       cmd_mask,
  input  logic [CNT_W-1:0]       cmd_len,
  input  logic                   abort,
  output logic [N_SUB*SUB_W-1:0] sub_err_ctrl,
  output logic [N_SUB-1:0]       sub_active,
  output logic                   busy,
  output logic                   bad_chan
);
  localparam logic [1:0] M_STOP = 2'd3;

  logic                        chan_ok, sel_act, bcast, fire;
  logic [N_SUB-1:0]            hit, act_nxt;
  logic [N_SUB-1:0][SUB_W-1:0] lane_err;

  assign chan_ok = (cmd_chan < CH_W'(N_SUB));

  always_comb begin
    sel_act = 1'b0;
    for (int i = 0; i < N_SUB; i++)
      if (cmd_chan == CH_W'(i)) sel_act = sub_active[i];
  end

`ifdef ERR_SPLIT_BCAST_EN
  assign bcast     = (cmd_chan == '1);
  assign cmd_ready = !abort && (bcast ? (!busy || cmd_mode == M_STOP)
                                      : (cmd_mode == M_STOP || !chan_ok || !sel_act));
`else
  assign bcast     = 1'b0;
  assign cmd_ready = !abort && (cmd_mode == M_STOP || !chan_ok || !sel_act);
`endif

  assign fire = cmd_valid && cmd_ready;

  for (genvar g = 0; g < N_SUB; g++) begin : g_lane
    assign hit[g] = fire && (bcast || cmd_chan == CH_W'(g));
    err_ctrl_lane #(.SUB_W(SUB_W), .CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .abort   (abort),
      .hit     (hit[g]),
      .mode    (cmd_mode),
      .mask    (cmd_mask),
      .len     (cmd_len),
      .err     (lane_err[g]),
      .active  (sub_active[g]),
      .act_nxt (act_nxt[g])
    );
  end

  assign sub_err_ctrl = lane_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      bad_chan <= 1'b0;
    end else begin
      busy <= |act_nxt;
      if (fire && !chan_ok && !bcast) bad_chan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_err_ctrl_distributor.sv
// Directed vector table plus randomized run against a remaining-cycles reference model.
module tb_err_ctrl_distributor;
  localparam int N = 4, W = 8, CW = 8, CH_W = 3;
  localparam logic [1:0] ONE = 2'd0, BST = 2'd1, CNT = 2'd2, STP = 2'd3;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            cmd_valid = 1'b0, cmd_ready, abort = 1'b0;
  logic [CH_W-1:0] cmd_chan = '0;
  logic [1:0]      cmd_mode = '0;
  logic [W-1:0]    cmd_mask = '0;
  logic [CW-1:0]   cmd_len = '0;
  logic [N*W-1:0]  sub_err_ctrl;
  logic [N-1:0]    sub_active;
  logic            busy, bad_chan;

  err_ctrl_distributor #(.N_SUB(N), .SUB_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_mode(cmd_mode), .cmd_mask(cmd_mask), .cmd_len(cmd_len),
    .abort(abort), .sub_err_ctrl(sub_err_ctrl), .sub_active(sub_active),
    .busy(busy), .bad_chan(bad_chan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [2:0] ch; logic [1:0] md; logic [7:0] mk; logic [7:0] len; logic ab;
    logic rdy; logic [31:0] err; logic [3:0] act; logic bad;
  } vec_t;

  vec_t tbl[19];
  int compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    @(negedge clk);
    cmd_valid = t.v; cmd_chan = t.ch; cmd_mode = t.md;
    cmd_mask = t.mk; cmd_len = t.len; abort = t.ab;
  endtask

  // One cycle: apply inputs, check ready before the edge and outputs after it.
  task automatic step(input vec_t t, input string nm);
    drive(t);
    #1 chk({nm, ".ready"}, 32'(cmd_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    chk({nm, ".err"},    sub_err_ctrl,   t.err);
    chk({nm, ".active"}, 32'(sub_active), 32'(t.act));
    chk({nm, ".busy"},   32'(busy),       32'(|t.act));
    chk({nm, ".bad"},    32'(bad_chan),   32'(t.bad));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_chan = '0; cmd_mode = ONE;
    #1;
    chk("rst.err", sub_err_ctrl, 32'h0);
    chk("rst.active", 32'(sub_active), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.bad", 32'(bad_chan), 32'h0);
    chk("rst.ready", 32'(cmd_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.err", sub_err_ctrl, 32'h0);
    chk("post_rst.ready", 32'(cmd_ready), 32'h1);
  endtask

  // Reference model: cycles left per channel (-1 = continuous), latched mask, sticky flag.
  int         rem[N];
  logic [7:0] mk_m[N];
  logic       bad_m;

  initial begin
    vec_t t;
    vec_t idle_ch0;
    tbl[0]  = '{1'b1, 3'd1, ONE, 8'hA5, 8'd0, 1'b0, 1'b1, 32'h0000A500, 4'b0010, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, ONE, 8'h00, 8'd0, 1'b0, 1'b1, 32'h00000000, 4'b0000, 1'b0};
    tbl[2]  = '{1'b1, 3'd0, BST, 8'h0F, 8'd3, 1'b0, 1'b1, 32'h0000000F, 4'b0001, 1'b0};
    tbl[3]  = '{1'b1, 3'd0, BST, 8'h0F, 8'd3, 1'b0, 1'b0, 32'h0000000F, 4'b0001, 1'b0};
    tbl[4]  = '{1'b1, 3'd0, BST, 8'h0F, 8'd3, 1'b0, 1'b0, 32'h0000000F, 4'b0001, 1'b0};
    tbl[5]  = '{1'b1, 3'd0, BST, 8'h0F, 8'd3, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0};
    tbl[6]  = '{1'b1, 3'd0, BST, 8'h0F, 8'd3, 1'b0, 1'b1, 32'h0000000F, 4'b0001, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, BST, 8'h0F, 8'd3, 1'b0, 1'b0, 32'h0000000F, 4'b0001, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, BST, 8'h0F, 8'd3, 1'b0, 1'b0, 32'h0000000F, 4'b0001, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, BST, 8'h0F, 8'd3, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0};
    tbl[10] = '{1'b1, 3'd0, BST, 8'h0F, 8'd0, 1'b0, 1'b1, 32'h0000000F, 4'b0001, 1'b0};
    tbl[11] = '{1'b1, 3'd0, BST, 8'h33, 8'd0, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0};
    tbl[12] = '{1'b1, 3'd0, BST, 8'h33, 8'd0, 1'b0, 1'b1, 32'h00000033, 4'b0001, 1'b0};
    tbl[13] = '{1'b0, 3'd0, ONE, 8'h00, 8'd0, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0};
    tbl[14] = '{1'b1, 3'd2, CNT, 8'hFF, 8'd0, 1'b0, 1'b1, 32'h00FF0000, 4'b0100, 1'b0};
    tbl[15] = '{1'b1, 3'd3, CNT, 8'h55, 8'd0, 1'b0, 1'b1, 32'h55FF0000, 4'b1100, 1'b0};
    tbl[16] = '{1'b1, 3'd1, ONE, 8'h11, 8'd0, 1'b1, 1'b0, 32'h00000000, 4'b0000, 1'b0};
    tbl[17] = '{1'b1, 3'd5, ONE, 8'hFF, 8'd0, 1'b0, 1'b1, 32'h00000000, 4'b0000, 1'b1};
    tbl[18] = '{1'b0, 3'd0, ONE, 8'h00, 8'd0, 1'b0, 1'b1, 32'h00000000, 4'b0000, 1'b1};

    do_reset();
    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));

    // bad_chan survives until reset, then clears.
    do_reset();

    // Continuous hold on ch2 for 10 cycles, then STOP.
    step('{1'b1, 3'd2, CNT, 8'hFF, 8'd0, 1'b0, 1'b1, 32'h00FF0000, 4'b0100, 1'b0}, "cont_go");
    for (int i = 0; i < 9; i++)
      step('{1'b0, 3'd2, CNT, 8'h00, 8'd0, 1'b0, 1'b0, 32'h00FF0000, 4'b0100, 1'b0}, "cont_hold");
    step('{1'b1, 3'd2, STP, 8'h00, 8'd0, 1'b0, 1'b1, 32'h00000000, 4'b0000, 1'b0}, "cont_stop");
    step('{1'b1, 3'd2, STP, 8'h00, 8'd0, 1'b0, 1'b1, 32'h00000000, 4'b0000, 1'b0}, "stop_idle");

    // Reset in the middle of a long burst truncates at once.
    step('{1'b1, 3'd1, BST, 8'h77, 8'd10, 1'b0, 1'b1, 32'h00007700, 4'b0010, 1'b0}, "mid_go");
    step('{1'b0, 3'd1, BST, 8'h00, 8'd0, 1'b0, 1'b0, 32'h00007700, 4'b0010, 1'b0}, "mid_run");
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("mid_rst.err", sub_err_ctrl, 32'h0);
    chk("mid_rst.active", 32'(sub_active), 32'h0);
    do_reset();

    // All-ones channel: broadcast when enabled, otherwise a bad index.
`ifdef ERR_SPLIT_BCAST_EN
    step('{1'b1, 3'd7, BST, 8'h3C, 8'd2, 1'b0, 1'b1, 32'h3C3C3C3C, 4'b1111, 1'b0}, "bc_go");
    step('{1'b1, 3'd7, BST, 8'h3C, 8'd2, 1'b0, 1'b0, 32'h3C3C3C3C, 4'b1111, 1'b0}, "bc_hold");
    step('{1'b0, 3'd7, BST, 8'h3C, 8'd2, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0}, "bc_end");
`else
    step('{1'b1, 3'd7, BST, 8'h3C, 8'd2, 1'b0, 1'b1, 32'h00000000, 4'b0000, 1'b1}, "bc_drop");
    step('{1'b0, 3'd7, BST, 8'h3C, 8'd2, 1'b0, 1'b1, 32'h00000000, 4'b0000, 1'b1}, "bc_sticky");
`endif

    // Randomized run against the reference model.
    do_reset();
    bad_m = 1'b0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; mk_m[i] = '0; end
    idle_ch0 = '{1'b0, 3'd0, ONE, 8'h00, 8'd0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit in_rng, bc, any, rdy_m, fire_m;
      logic [31:0] exp_err;
      logic [3:0]  exp_act;
      t = idle_ch0;
      t.v   = ($urandom_range(0, 9) < 7);
      t.ch  = 3'($urandom_range(0, 7));
      t.md  = 2'($urandom_range(0, 3));
      t.mk  = 8'($urandom);
      t.len = 8'($urandom_range(0, 5));
      t.ab  = ($urandom_range(0, 15) == 0);
      in_rng = (int'(t.ch) < N);
`ifdef ERR_SPLIT_BCAST_EN
      bc = (t.ch == 3'd7);
`else
      bc = 1'b0;
`endif
      any = 1'b0;
      for (int i = 0; i < N; i++) if (rem[i] != 0) any = 1'b1;
      if (bc) rdy_m = !t.ab && (!any || t.md == STP);
      else    rdy_m = !t.ab && (t.md == STP || !in_rng || rem[t.ch] == 0);
      fire_m = t.v && rdy_m;
      drive(t);
      #1 chk("rnd.ready", 32'(cmd_ready), 32'(rdy_m));
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        if (t.ab) rem[i] = 0;
        else begin
          if (rem[i] > 0) rem[i]--;
          if (fire_m && (bc || int'(t.ch) == i)) begin
            case (t.md)
              ONE: rem[i] = 1;
              BST: rem[i] = (t.len == 0) ? 1 : int'(t.len);
              CNT: rem[i] = -1;
              default: rem[i] = 0;
            endcase
            if (t.md != STP) mk_m[i] = t.mk;
          end
        end
      end
      if (fire_m && !in_rng && !bc) bad_m = 1'b1;
      exp_err = '0; exp_act = '0;
      for (int i = 0; i < N; i++)
        if (rem[i] != 0) begin exp_err[i*W +: W] = mk_m[i]; exp_act[i] = 1'b1; end
      #1;
      chk("rnd.err", sub_err_ctrl, exp_err);
      chk("rnd.active", 32'(sub_active), 32'(exp_act));
      chk("rnd.busy", 32'(busy), 32'(|exp_act));
      chk("rnd.bad", 32'(bad_chan), 32'(bad_m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
